pwm_multi_ch: RTL and testbench
===============================

# pwm_multi_ch

Parametrised multi-channel PWM generator. It is the next-generation replacement for the fixed 3-channel, 32-bit PWM core instantiated ahead of the pin pads. Each channel adds the following over that core:
- its own prescaler;
- edge- or center-aligned counting;
- output polarity;
- double-buffered (shadow) configuration, applied only at a period boundary, so duty or period changes never produce runt pulses.

Outputs drive the pad data and pad output-enable pins directly.

## Interface
- N_CH, 3, number of independent channels
- CNT_W, 32, width of period, duty and counter
- PRE_W, 32, width of prescaler and prescaler counter

- clk_i  in  1  single clock; all logic on rising edge
- rst_i  in  1  synchronous reset, active-high
- enable_i  in  N_CH  per-channel run enable (level)
- update_i  in  N_CH  per-channel one-cycle strobe: capture config inputs into shadow
- mode_i  in  N_CH  0 = edge-aligned, 1 = center-aligned
- polarity_i  in  N_CH  1 = invert output and idle level
- prescaler_i  in  N_CH x PRE_W  tick every prescaler+1 clocks
- period_i  in  N_CH x CNT_W  period value P
- duty_i  in  N_CH x CNT_W  duty value D
- pwm_o  out  N_CH  registered PWM output (to pad data)
- oen_o  out  N_CH  registered pad output-enable, 1 = drive
- period_end_o  out  N_CH  registered one-cycle pulse per completed period

## Operation

**Per-channel state:**
- shadow set {prescaler, period, duty, mode, polarity};
- pending flag;
- active set (same fields);
- pre_cnt[PRE_W], cnt[CNT_W], dir (up/down).

**Shadow capture:**
- update_i[c]=1 writes inputs into shadow and sets pending.
- Config inputs are ignored when update_i[c]=0.

**Apply:** active <= shadow and pending cleared when pending=1 and either of these holds:
- enable_i[c]=0 (applied on the next edge), or
- a boundary tick occurs.

On a boundary apply, cnt <= 0, dir <= up and pre_cnt <= 0.

**Simultaneous update_i and apply edge:** the incoming inputs bypass the shadow and load straight into active; pending ends at 0.

**Disabled (enable_i[c]=0):**
- pre_cnt=0, cnt=0, dir=up;
- pwm_o <= active polarity, oen_o <= 0, period_end_o <= 0.

**Prescaler (enabled):**
- tick = (pre_cnt == act_prescaler).
- pre_cnt <= tick ? 0 : pre_cnt+1.
- act_prescaler=0 gives a tick every clock.

**Edge mode:**
- On tick: cnt <= (cnt == P) ? 0 : cnt+1.
- Boundary = tick && cnt == P.
- Output period = (P+1)*(prescaler+1) clocks.

**Center mode (P ≥ 1):**
- Up direction, on tick: cnt<P gives cnt+1; cnt==P gives cnt-1 and dir<=down.
- Down direction, on tick: cnt>0 gives cnt-1; cnt==0 gives cnt<=1 and dir<=up.
- Boundary = tick && dir==down && cnt==0.
- Output period = 2P ticks.
- Center mode with P=0 behaves exactly as edge mode with P=0.

**Output (enabled):**
- pwm_o <= (cnt < D) ^ pol, using the current cnt and active D/pol.
- D=0 gives a constant inactive level.
- D > P gives a constant active level.

**Flags (enabled):**
- oen_o <= 1.
- period_end_o <= boundary.

**Arithmetic:** compares are unsigned and full width; cnt never exceeds the active P.

**Channel independence:** channels are fully independent; there is no shared state.

## Timing
- **Reset values:**
  - all active and shadow fields 0, pending 0, pre_cnt/cnt 0, dir up;
  - pwm_o=0, oen_o=0, period_end_o=0.
- **Output latency:** pwm_o, oen_o and period_end_o reflect the counter state one clock earlier (one registered stage).
- **First enabled edge:** enable_i rising, sampled at edge E0, gives:
  - oen_o=1 and pwm_o=(0<D)^pol after E0;
  - cnt=1 after E0 if prescaler=0.
- **Mid-operation disable:** counters clear on the next edge and the output returns to idle. Re-enabling always restarts from cnt=0.
- **Reset mid-operation:** returns every register to its reset value on the next edge, including any pending shadow.
- **Config change while running:**
  - Changed input values have no effect until update_i.
  - An update takes effect at the first boundary tick at or after its strobe.

## Test plan
1. **Edge mode, basic waveform.**
   - Stimulus: update with prescaler=0, P=3, D=2, pol=0, mode=0 while disabled; then enable.
   - Required: pwm_o = 1,1,0,0 repeating from E0; period_end_o pulses every 4 clocks, coincident with the last 0.
2. **Prescaler and polarity.**
   - Stimulus: prescaler=1, P=3, D=1, pol=1.
   - Required: pwm_o low for 2 clocks, high for 6 clocks, period 8; period_end_o pulses every 8 clocks.
3. **Center mode.**
   - Stimulus: P=4, D=2, prescaler=0; run for several periods.
   - Required: steady-state cnt = 1,2,3,4,3,2,1,0; pwm_o high for 3 clocks per 8-clock period, centred on cnt=0; period_end_o every 8 clocks.
4. **Shadowed update while running.**
   - Stimulus: in config 1, strobe update with D=3 at cnt=1.
   - Required: the current period stays 1,1,0,0; the following period is 1,1,1,0. Also strobe update on the exact boundary edge and check the bypass path gives the same result.
5. **Duty extremes.**
   - Stimulus: D=0, then D=P+1.
   - Required: pwm_o constant inactive, then constant active; period_end_o still pulses every P+1 clocks.
6. **Disable and reset.**
   - Stimulus: disable mid-period, and separately assert rst_i mid-period.
   - Required, disable: pwm_o equals pol and oen_o=0 next clock; re-enabling restarts at cnt=0.
   - Required, reset: all outputs 0 and pending cleared; a later enable without update leaves pwm_o constant inactive.
7. **Channel independence.**
   - Stimulus: N_CH=3 with distinct configs.
   - Required: each channel matches its own model, with no cross-channel interaction.

Source files
------------

// File: rtl/pwm_multi_ch.sv
// pwm_multi_ch: N_CH independent PWM channels. Each channel has its own
// prescaler, edge/center counting, polarity and shadowed configuration.
// Ports: clk_i/rst_i (sync, active-high); per channel: enable_i, update_i,
// mode_i, polarity_i, prescaler_i, period_i, duty_i in; pwm_o, oen_o,
// period_end_o out (all registered).
module pwm_multi_ch #(
  parameter int N_CH  = 3,
  parameter int CNT_W = 32,
  parameter int PRE_W = 32
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [N_CH-1:0]             enable_i,
  input  logic [N_CH-1:0]             update_i,
  input  logic [N_CH-1:0]             mode_i,
  input  logic [N_CH-1:0]             polarity_i,
  input  logic [N_CH-1:0][PRE_W-1:0]  prescaler_i,
  input  logic [N_CH-1:0][CNT_W-1:0]  period_i,
  input  logic [N_CH-1:0][CNT_W-1:0]  duty_i,
  output logic [N_CH-1:0]             pwm_o,
  output logic [N_CH-1:0]             oen_o,
  output logic [N_CH-1:0]             period_end_o
);

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    logic [PRE_W-1:0] r_sh_pre, r_act_pre, r_pre_cnt;
    logic [CNT_W-1:0] r_sh_per, r_sh_duty;
    logic [CNT_W-1:0] r_act_per, r_act_duty, r_cnt;
    logic             r_sh_mode, r_sh_pol;
    logic             r_act_mode, r_act_pol;
    logic             r_pend, r_dir;
    logic             r_pwm, r_oen, r_pe;

    logic             w_tick, w_center, w_bnd, w_apply;
    logic             w_en, w_upd, w_dir_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;

    assign w_en     = enable_i[c];
    assign w_upd    = update_i[c];
    assign w_tick   = (r_pre_cnt == r_act_pre);
    // Center mode with P=0 degenerates to the edge counter.
    assign w_center = r_act_mode && (r_act_per != '0);

    // r_dir: 0 = counting up, 1 = counting down.
    always_comb begin
      w_cnt_nxt = r_cnt;
      w_dir_nxt = r_dir;
      w_bnd     = 1'b0;
      if (!w_center) begin
        w_bnd = w_tick && (r_cnt == r_act_per);
        if (w_tick) begin
          if (r_cnt == r_act_per) w_cnt_nxt = '0;
          else                    w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end else if (!r_dir) begin
        if (w_tick) begin
          if (r_cnt < r_act_per) begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end else begin
            w_cnt_nxt = r_cnt - CNT_W'(1);
            w_dir_nxt = 1'b1;
          end
        end
      end else begin
        w_bnd = w_tick && (r_cnt == '0);
        if (w_tick) begin
          if (r_cnt != '0) begin
            w_cnt_nxt = r_cnt - CNT_W'(1);
          end else begin
            w_cnt_nxt = CNT_W'(1);
            w_dir_nxt = 1'b0;
          end
        end
      end
    end

    // A strobe coinciding with an apply edge counts as pending.
    assign w_apply = (r_pend || w_upd) && (!w_en || w_bnd);

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        r_sh_pre   <= '0;
        r_sh_per   <= '0;
        r_sh_duty  <= '0;
        r_sh_mode  <= 1'b0;
        r_sh_pol   <= 1'b0;
        r_act_pre  <= '0;
        r_act_per  <= '0;
        r_act_duty <= '0;
        r_act_mode <= 1'b0;
        r_act_pol  <= 1'b0;
        r_pend     <= 1'b0;
        r_pre_cnt  <= '0;
        r_cnt      <= '0;
        r_dir      <= 1'b0;
        r_pwm      <= 1'b0;
        r_oen      <= 1'b0;
        r_pe       <= 1'b0;
      end else begin
        if (w_upd) begin
          r_sh_pre  <= prescaler_i[c];
          r_sh_per  <= period_i[c];
          r_sh_duty <= duty_i[c];
          r_sh_mode <= mode_i[c];
          r_sh_pol  <= polarity_i[c];
          r_pend    <= 1'b1;
        end
        if (w_apply) begin
          r_pend <= 1'b0;
          if (w_upd) begin
            r_act_pre  <= prescaler_i[c];
            r_act_per  <= period_i[c];
            r_act_duty <= duty_i[c];
            r_act_mode <= mode_i[c];
            r_act_pol  <= polarity_i[c];
          end else begin
            r_act_pre  <= r_sh_pre;
            r_act_per  <= r_sh_per;
            r_act_duty <= r_sh_duty;
            r_act_mode <= r_sh_mode;
            r_act_pol  <= r_sh_pol;
          end
        end
        if (!w_en) begin
          r_pre_cnt <= '0;
          r_cnt     <= '0;
          r_dir     <= 1'b0;
          r_pwm     <= r_act_pol;
          r_oen     <= 1'b0;
          r_pe      <= 1'b0;
        end else begin
          r_pwm <= (r_cnt < r_act_duty) ^ r_act_pol;
          r_oen <= 1'b1;
          r_pe  <= w_bnd;
          if (w_apply) begin
            r_pre_cnt <= '0;
            r_cnt     <= '0;
            r_dir     <= 1'b0;
          end else begin
            r_pre_cnt <= w_tick ? '0 : r_pre_cnt + PRE_W'(1);
            r_cnt     <= w_cnt_nxt;
            r_dir     <= w_dir_nxt;
          end
        end
      end
    end

    assign pwm_o[c]        = r_pwm;
    assign oen_o[c]        = r_oen;
    assign period_end_o[c] = r_pe;
  end

endmodule

// File: tb/tb_pwm_multi_ch.sv
// tb_pwm_multi_ch: scenario tasks plus randomized traffic, checked
// against a waveform model built from period/tick arithmetic.
module tb_pwm_multi_ch;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic [2:0]       enable_i, update_i, mode_i, polarity_i;
  logic [2:0][31:0] prescaler_i, period_i, duty_i;
  logic [2:0]       pwm_o, oen_o, period_end_o;

  int n_chk  = 0;
  int n_fail = 0;

  pwm_multi_ch #(.N_CH(3), .CNT_W(32), .PRE_W(32)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .enable_i     (enable_i),
    .update_i     (update_i),
    .mode_i       (mode_i),
    .polarity_i   (polarity_i),
    .prescaler_i  (prescaler_i),
    .period_i     (period_i),
    .duty_i       (duty_i),
    .pwm_o        (pwm_o),
    .oen_o        (oen_o),
    .period_end_o (period_end_o)
  );

  always #5 clk_i = ~clk_i;

  // Model: config sets plus k = clocks elapsed since the counter restarted.
  longint m_s_pre[3], m_s_per[3], m_s_duty[3];
  bit     m_s_mode[3], m_s_pol[3], m_pend[3];
  longint m_a_pre[3], m_a_per[3], m_a_duty[3];
  bit     m_a_mode[3], m_a_pol[3];
  longint m_k[3];
  logic [2:0] e_pwm, e_oen, e_pe;

  function automatic void m_pos(input int c, output longint cnt,
                                output bit bnd);
    longint t, j, sub, u, p;
    bit last;
    p    = m_a_per[c];
    t    = m_a_pre[c] + 1;
    j    = m_k[c] / t;
    sub  = m_k[c] % t;
    last = (sub == m_a_pre[c]);
    if (!m_a_mode[c] || p == 0) begin
      cnt = j % (p + 1);
      bnd = last && (cnt == p);
    end else if (j == 0) begin
      cnt = 0;
      bnd = 1'b0;
    end else begin
      // triangle after the first ramp: 1..P..0 repeating every 2P ticks
      u   = (j - 1) % (2 * p);
      cnt = (u < p) ? u + 1 : 2 * p - 1 - u;
      bnd = last && (u == 2 * p - 1);
    end
  endfunction

  task automatic model_step();
    for (int c = 0; c < 3; c++) begin
      longint cnt;
      bit bnd, ap;
      if (rst_i) begin
        m_s_pre[c] = 0; m_s_per[c] = 0; m_s_duty[c] = 0;
        m_s_mode[c] = 0; m_s_pol[c] = 0; m_pend[c] = 0;
        m_a_pre[c] = 0; m_a_per[c] = 0; m_a_duty[c] = 0;
        m_a_mode[c] = 0; m_a_pol[c] = 0; m_k[c] = 0;
        e_pwm[c] = 0; e_oen[c] = 0; e_pe[c] = 0;
      end else begin
        m_pos(c, cnt, bnd);
        if (enable_i[c]) begin
          e_pwm[c] = (cnt < m_a_duty[c]) ^ m_a_pol[c];
          e_oen[c] = 1'b1;
          e_pe[c]  = bnd;
        end else begin
          e_pwm[c] = m_a_pol[c];
          e_oen[c] = 1'b0;
          e_pe[c]  = 1'b0;
        end
        ap = (m_pend[c] || update_i[c]) && (!enable_i[c] || bnd);
        if (update_i[c]) begin
          m_s_pre[c]  = prescaler_i[c];
          m_s_per[c]  = period_i[c];
          m_s_duty[c] = duty_i[c];
          m_s_mode[c] = mode_i[c];
          m_s_pol[c]  = polarity_i[c];
          m_pend[c]   = 1'b1;
        end
        if (ap) begin
          m_a_pre[c]  = m_s_pre[c];
          m_a_per[c]  = m_s_per[c];
          m_a_duty[c] = m_s_duty[c];
          m_a_mode[c] = m_s_mode[c];
          m_a_pol[c]  = m_s_pol[c];
          m_pend[c]   = 1'b0;
          m_k[c]      = 0;
        end else begin
          m_k[c] = enable_i[c] ? m_k[c] + 1 : 0;
        end
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk_i);
    model_step();
    #1;
  endtask

  task automatic set_cfg(input int c, input int pre, input int p,
                         input int d, input bit m, input bit po);
    prescaler_i[c] = 32'(pre);
    period_i[c]    = 32'(p);
    duty_i[c]      = 32'(d);
    mode_i[c]      = m;
    polarity_i[c]  = po;
  endtask

  task automatic load0(input int pre, input int p, input int d,
                       input bit m, input bit po);
    enable_i[0] = 1'b0;
    set_cfg(0, pre, p, d, m, po);
    update_i[0] = 1'b1;
    cyc();
    update_i[0] = 1'b0;
    cyc();
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    enable_i = 3'b111;
    update_i = 3'b111;
    for (int c = 0; c < 3; c++) set_cfg(c, 1, 5, 2, 1, 1);
    for (int i = 0; i < 3; i++) begin
      cyc();
      n_chk++;
      if ({pwm_o, oen_o, period_end_o} !== 9'h0) begin
        n_fail++;
        $display("FAIL reset i=%0d got=%b exp=0", i,
                 {pwm_o, oen_o, period_end_o});
      end
    end
    enable_i = 3'b000;
    update_i = 3'b000;
    rst_i = 1'b0;
    cyc();
  endtask

  task automatic test_edge_basic();
    load0(0, 3, 2, 0, 0);
    enable_i[0] = 1'b1;
    for (int i = 0; i < 12; i++) begin
      cyc();
      n_chk++;
      if (pwm_o[0] !== ((i % 4) < 2) || period_end_o[0] !== ((i % 4) == 3)
          || oen_o[0] !== 1'b1) begin
        n_fail++;
        $display("FAIL edge_basic i=%0d got pwm=%b pe=%b oen=%b", i,
                 pwm_o[0], period_end_o[0], oen_o[0]);
      end
      n_chk++;
      if ({pwm_o, oen_o, period_end_o} !== {e_pwm, e_oen, e_pe}) begin
        n_fail++;
        $display("FAIL edge_model i=%0d got=%b exp=%b", i,
                 {pwm_o, oen_o, period_end_o}, {e_pwm, e_oen, e_pe});
      end
    end
  endtask

  task automatic test_prescaler_pol();
    load0(1, 3, 1, 0, 1);
    enable_i[0] = 1'b1;
    for (int i = 0; i < 24; i++) begin
      cyc();
      n_chk++;
      if (pwm_o[0] !== ((i % 8) >= 2) || period_end_o[0] !== ((i % 8) == 7))
      begin
        n_fail++;
        $display("FAIL presc_pol i=%0d got pwm=%b pe=%b", i,
                 pwm_o[0], period_end_o[0]);
      end
    end
  endtask

  task automatic test_center();
    int hi;
    load0(0, 4, 2, 1, 0);
    enable_i[0] = 1'b1;
    hi = 0;
    for (int i = 0; i < 25; i++) begin
      cyc();
      if (i >= 8 && i < 16) hi += int'(pwm_o[0]);
      n_chk++;
      if (pwm_o[0] !== (i == 0 || (i % 8) == 7 || (i % 8) <= 1) ||
          period_end_o[0] !== (i > 0 && (i % 8) == 0)) begin
        n_fail++;
        $display("FAIL center i=%0d got pwm=%b pe=%b", i,
                 pwm_o[0], period_end_o[0]);
      end
      n_chk++;
      if ({pwm_o, oen_o, period_end_o} !== {e_pwm, e_oen, e_pe}) begin
        n_fail++;
        $display("FAIL center_model i=%0d got=%b exp=%b", i,
                 {pwm_o, oen_o, period_end_o}, {e_pwm, e_oen, e_pe});
      end
    end
    n_chk++;
    if (hi != 3) begin
      n_fail++;
      $display("FAIL center_high got=%0d exp=3", hi);
    end
  endtask

  task automatic test_shadow_update();
    bit exp[16] = '{1,1,0,0, 1,1,1,0, 1,1,1,0, 1,0,0,0};
    load0(0, 3, 2, 0, 0);
    enable_i[0] = 1'b1;
    for (int i = 0; i < 16; i++) begin
      update_i[0] = 1'b0;
      if (i == 1) begin duty_i[0] = 32'd3; update_i[0] = 1'b1; end
      if (i == 6) duty_i[0] = 32'd0;
      if (i == 11) begin duty_i[0] = 32'd1; update_i[0] = 1'b1; end
      cyc();
      n_chk++;
      if (pwm_o[0] !== exp[i]) begin
        n_fail++;
        $display("FAIL shadow i=%0d got=%b exp=%b", i, pwm_o[0], exp[i]);
      end
      n_chk++;
      if ({pwm_o, oen_o, period_end_o} !== {e_pwm, e_oen, e_pe}) begin
        n_fail++;
        $display("FAIL shadow_model i=%0d got=%b exp=%b", i,
                 {pwm_o, oen_o, period_end_o}, {e_pwm, e_oen, e_pe});
      end
    end
    update_i[0] = 1'b0;
  endtask

  task automatic test_duty_extremes();
    for (int ph = 0; ph < 2; ph++) begin
      load0(0, 3, (ph == 0) ? 0 : 4, 0, 0);
      enable_i[0] = 1'b1;
      for (int i = 0; i < 12; i++) begin
        cyc();
        n_chk++;
        if (pwm_o[0] !== bit'(ph) || period_end_o[0] !== ((i % 4) == 3)) begin
          n_fail++;
          $display("FAIL duty_ext ph=%0d i=%0d got pwm=%b pe=%b exp pwm=%0d",
                   ph, i, pwm_o[0], period_end_o[0], ph);
        end
      end
    end
  endtask

  task automatic test_disable_reset();
    load0(0, 3, 2, 0, 1);
    enable_i[0] = 1'b1;
    repeat (3) cyc();
    enable_i[0] = 1'b0;
    cyc();
    n_chk++;
    if (pwm_o[0] !== 1'b1 || oen_o[0] !== 1'b0 || period_end_o[0] !== 1'b0)
    begin
      n_fail++;
      $display("FAIL disable got pwm=%b oen=%b exp pwm=1 oen=0",
               pwm_o[0], oen_o[0]);
    end
    cyc();
    enable_i[0] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      n_chk++;
      if (pwm_o[0] !== (i >= 2)) begin
        n_fail++;
        $display("FAIL reenable i=%0d got=%b exp=%0d", i, pwm_o[0], i >= 2);
      end
    end
    set_cfg(0, 0, 5, 5, 0, 0);
    update_i[0] = 1'b1;
    cyc();
    update_i[0] = 1'b0;
    rst_i = 1'b1;
    cyc();
    n_chk++;
    if ({pwm_o, oen_o, period_end_o} !== 9'h0) begin
      n_fail++;
      $display("FAIL mid_reset got=%b exp=0", {pwm_o, oen_o, period_end_o});
    end
    rst_i = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cyc();
      n_chk++;
      if (pwm_o[0] !== 1'b0 || oen_o[0] !== 1'b1) begin
        n_fail++;
        $display("FAIL post_reset i=%0d got pwm=%b oen=%b exp pwm=0 oen=1",
                 i, pwm_o[0], oen_o[0]);
      end
    end
  endtask

  task automatic test_random_multi();
    enable_i = 3'b000;
    for (int c = 0; c < 3; c++) begin
      set_cfg(c, c, 3 + 2 * c, 1 + c, bit'(c == 1), bit'(c == 2));
    end
    update_i = 3'b111;
    cyc();
    update_i = 3'b000;
    enable_i = 3'b111;
    for (int i = 0; i < 4000; i++) begin
      for (int c = 0; c < 3; c++) begin
        update_i[c] = ($urandom_range(0, 15) == 0);
        if ($urandom_range(0, 7) == 0 || update_i[c]) begin
          set_cfg(c, int'($urandom_range(0, 3)), int'($urandom_range(0, 9)),
                  int'($urandom_range(0, 11)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)));
        end
        if ($urandom_range(0, 63) == 0) enable_i[c] = ~enable_i[c];
      end
      rst_i = ($urandom_range(0, 999) == 0);
      cyc();
      n_chk++;
      if ({pwm_o, oen_o, period_end_o} !== {e_pwm, e_oen, e_pe}) begin
        n_fail++;
        $display("FAIL random i=%0d got=%b exp=%b", i,
                 {pwm_o, oen_o, period_end_o}, {e_pwm, e_oen, e_pe});
      end
    end
    rst_i = 1'b0;
    update_i = 3'b000;
  endtask

  initial begin
    rst_i = 1'b1;
    enable_i = '0;
    update_i = '0;
    mode_i = '0;
    polarity_i = '0;
    prescaler_i = '0;
    period_i = '0;
    duty_i = '0;
    test_reset();
    test_edge_basic();
    test_prescaler_pol();
    test_center();
    test_shadow_update();
    test_duty_extremes();
    test_disable_reset();
    test_random_multi();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
